// File: rtl/nabp_multi_shifter_if.sv
// nabp_multi_shifter_if
//   Handshake/bus bundle between NABP state control, the multi-channel shift
//   controller and the per-angle mapper / line-buffer lanes.
//   master : state-control side (drives kicks, hold, abort, per-lane steps)
//   slave  : shift controller side (drives enables, clears and done pulses)
//   sc_accu_base packs one W-bit unsigned fixed-point step per lane,
//   lane c at [c*W +: W].
interface nabp_multi_shifter_if #(
    parameter int CHANNELS = 4,
    parameter int W        = 12
);
    logic                  sc_fill_kick;
    logic                  sc_shift_kick;
    logic [CHANNELS*W-1:0] sc_accu_base;
    logic                  sc_hold;
    logic                  sc_abort;
    logic                  sc_fill_done;
    logic                  sc_shift_done;
    logic                  mp_kick;
    logic                  mp_done;
    logic [CHANNELS-1:0]   mp_shift_en;
    logic                  lb_clear;
    logic [CHANNELS-1:0]   lb_shift_en;
    logic                  sw_pe_en;
    logic                  busy;

    modport master (
        output sc_fill_kick, sc_shift_kick, sc_accu_base, sc_hold, sc_abort,
        input  sc_fill_done, sc_shift_done, mp_kick, mp_done, mp_shift_en,
               lb_clear, lb_shift_en, sw_pe_en, busy
    );

    modport slave (
        input  sc_fill_kick, sc_shift_kick, sc_accu_base, sc_hold, sc_abort,
        output sc_fill_done, sc_shift_done, mp_kick, mp_done, mp_shift_en,
               lb_clear, lb_shift_en, sw_pe_en, busy
    );
endinterface

// File: rtl/nabp_multi_shifter.sv
// nabp_multi_shifter
//   Multi-channel shift controller for the NABP back-projection datapath.
//   A common fill phase shifts every lane FILL_LEN times; the following
//   shift phase runs IMAGE_SIZE cycles in which each lane shifts whenever
//   the integer part of its fixed-point accumulator changes.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : nabp_multi_shifter_if.slave (kicks, hold, abort, lane steps in;
//             mapper / line-buffer enables, PE enable, done pulses, busy out)
//   lb_shift_en, sw_pe_en and both done pulses lag their internal versions
//   by DELAY registers; mp_kick, lb_clear and mp_shift_en are combinational.

// Per-lane accumulator: holds the latched step and the running position.
// shift is high when adding the step moves the integer part (after wrap).
module nabp_multi_shifter_lane #(
    parameter int ACC_INT  = 2,
    parameter int ACC_FRAC = 10,
    parameter int W        = ACC_INT + ACC_FRAC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] base_in,
    output logic         shift
);
    logic [W-1:0] acc;
    logic [W-1:0] base;
    logic [W-1:0] sum;

    assign sum   = acc + base;
    assign shift = sum[W-1 -: ACC_INT] != acc[W-1 -: ACC_INT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            base <= '0;
        end else if (load) begin
            base <= base_in;
            acc  <= '0;
        end else if (step) begin
            acc  <= sum;
        end
    end
endmodule

module nabp_multi_shifter #(
    parameter int IMAGE_SIZE = 128,
    parameter int FILL_LEN   = 64,
    parameter int CHANNELS   = 4,
    parameter int ACC_INT    = 2,
    parameter int ACC_FRAC   = 10,
    parameter int DELAY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    nabp_multi_shifter_if.slave   bus
);
    localparam int W  = ACC_INT + ACC_FRAC;
    localparam int CW = (IMAGE_SIZE > 2) ? $clog2(IMAGE_SIZE) : 1;
    localparam logic [CW-1:0] FILL_CNT  = CW'(FILL_LEN);
    localparam logic [CW-1:0] SHIFT_CNT = CW'(IMAGE_SIZE - 1);

    generate
        if (FILL_LEN > IMAGE_SIZE - 1 || CHANNELS < 1 || DELAY < 1) begin : g_bad_cfg
            $error("nabp_multi_shifter: need FILL_LEN <= IMAGE_SIZE-1, CHANNELS >= 1, DELAY >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {READY, FILL, FILL_DONE, SHIFT} state_t;

    // Everything that travels through the output delay line.
    typedef struct packed {
        logic                fill_done;
        logic                shift_done;
        logic                pe_en;
        logic [CHANNELS-1:0] shift_en;
    } dly_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                cnt_zero;
    logic                run;
    logic                fill_acc;
    logic                shift_acc;
    logic                lane_step;
    logic [CHANNELS-1:0] lane_shift;
    dly_t                pre;
    dly_t [DELAY:1]      dly_pipe;

    assign cnt_zero  = (cnt == '0);
    // A cycle makes progress only when not stalled, aborted or in reset;
    // gating with reset keeps the combinational outputs low during reset.
    assign run       = !bus.sc_hold && !bus.sc_abort && !reset;
    assign fill_acc  = (state == READY) && bus.sc_fill_kick && !bus.sc_abort && !reset;
    assign shift_acc = (state == FILL_DONE) && bus.sc_shift_kick && !bus.sc_abort;
    assign lane_step = (state == SHIFT) && run && !cnt_zero;

    always_comb begin
        pre = '0;
        if (run && state == FILL) begin
            if (cnt_zero) pre.fill_done = 1'b1;
            else          pre.shift_en  = '1;
        end
        if (run && state == SHIFT) begin
            pre.shift_en   = lane_shift;
            pre.pe_en      = 1'b1;
            pre.shift_done = cnt_zero;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
            nabp_multi_shifter_lane #(
                .ACC_INT  (ACC_INT),
                .ACC_FRAC (ACC_FRAC)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .load    (shift_acc),
                .step    (lane_step),
                .base_in (bus.sc_accu_base[c*W +: W]),
                .shift   (lane_shift[c])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= READY;
            cnt      <= '0;
            dly_pipe <= '0;
        end else if (bus.sc_abort) begin
            // Abort wins over everything and flushes in-flight enables/dones.
            state    <= READY;
            cnt      <= '0;
            dly_pipe <= '0;
        end else begin
            dly_pipe[1] <= pre;
            for (int i = 2; i <= DELAY; i++) dly_pipe[i] <= dly_pipe[i-1];
            case (state)
                READY: begin
                    if (bus.sc_fill_kick) begin
                        state <= FILL;
                        cnt   <= FILL_CNT;
                    end
                end
                FILL: begin
                    if (!bus.sc_hold) begin
                        if (cnt_zero) state <= FILL_DONE;
                        else          cnt   <= cnt - 1'b1;
                    end
                end
                FILL_DONE: begin
                    if (bus.sc_shift_kick) begin
                        state <= SHIFT;
                        cnt   <= SHIFT_CNT;
                    end
                end
                SHIFT: begin
                    if (!bus.sc_hold) begin
                        if (cnt_zero) state <= READY;
                        else          cnt   <= cnt - 1'b1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign bus.mp_kick       = fill_acc;
    assign bus.lb_clear      = fill_acc;
    assign bus.mp_shift_en   = pre.shift_en;
    assign bus.lb_shift_en   = dly_pipe[DELAY].shift_en;
    assign bus.sw_pe_en      = dly_pipe[DELAY].pe_en;
    assign bus.sc_fill_done  = dly_pipe[DELAY].fill_done;
    assign bus.sc_shift_done = dly_pipe[DELAY].shift_done;
    assign bus.mp_done       = dly_pipe[DELAY].shift_done;
    assign bus.busy          = (state != READY);
endmodule
